// File: rtl/ps2_command_out.sv
// PS/2 host-to-device command transmitter.
// Sends one byte with odd parity and checks the device ACK.
module ps2_command_out #(
   parameter int INHIBIT_CYCLES  = 6000,
   parameter int START_TIMEOUT   = 750000,
   parameter int BIT_TIMEOUT     = 100000,
   parameter int RELEASE_TIMEOUT = 100000
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [7:0] the_command,
   input  logic       send_command,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       busy,
   output logic       command_was_sent,
   output logic       error_communication_timed_out
);

   localparam int MAX_AB = (START_TIMEOUT > BIT_TIMEOUT) ?
                           START_TIMEOUT : BIT_TIMEOUT;
   localparam int MAX_CD = (RELEASE_TIMEOUT > INHIBIT_CYCLES) ?
                           RELEASE_TIMEOUT : INHIBIT_CYCLES;
   localparam int MAX_T  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int TW     = $clog2(MAX_T + 1);

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      WAIT_START,
      TX,
      WAIT_RELEASE,
      DONE,
      ERROR
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [3:0]    count_q, count_d;
   logic [9:0]    frame_q, frame_d;
   logic          bit_q, bit_d;
   logic          restart;

   logic clk_s1_q, clk_s2_q, clk_prev_q;
   logic dat_s1_q, dat_s2_q;
   logic fall;

   logic clk_oe_q, clk_oe_d;
   logic dat_oe_q, dat_oe_d;
   logic busy_q, busy_d;
   logic sent_q, sent_d;
   logic err_q, err_d;

   assign fall = clk_prev_q & ~clk_s2_q;

   // State, synchronizers and registered outputs
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         count_q    <= '0;
         frame_q    <= '0;
         bit_q      <= 1'b1;
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         clk_prev_q <= 1'b1;
         dat_s1_q   <= 1'b1;
         dat_s2_q   <= 1'b1;
         clk_oe_q   <= 1'b0;
         dat_oe_q   <= 1'b0;
         busy_q     <= 1'b0;
         sent_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         count_q    <= count_d;
         frame_q    <= frame_d;
         bit_q      <= bit_d;
         clk_s1_q   <= ps2_clk_in;
         clk_s2_q   <= clk_s1_q;
         clk_prev_q <= clk_s2_q;
         dat_s1_q   <= ps2_dat_in;
         dat_s2_q   <= dat_s1_q;
         clk_oe_q   <= clk_oe_d;
         dat_oe_q   <= dat_oe_d;
         busy_q     <= busy_d;
         sent_q     <= sent_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      frame_d = frame_q;
      bit_d   = bit_q;
      restart = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (send_command) begin
               frame_d = {1'b1, ~^the_command, the_command};
               count_d = '0;
               state_d = INHIBIT;
            end
         end
         INHIBIT: begin
            if (timer_q == TW'(INHIBIT_CYCLES - 1))
               state_d = REQ;
         end
         REQ: state_d = WAIT_START;
         WAIT_START: begin
            if (fall) begin
               bit_d   = frame_q[0];
               frame_d = {1'b0, frame_q[9:1]};
               count_d = 4'd1;
               state_d = TX;
            end else if (timer_q >= TW'(START_TIMEOUT)) begin
               state_d = ERROR;
            end
         end
         TX: begin
            if (fall) begin
               restart = 1'b1;
               // 11th edge: device must hold data low as ACK
               if (count_q == 4'd10) begin
                  state_d = dat_s2_q ? ERROR : WAIT_RELEASE;
               end else begin
                  bit_d   = frame_q[0];
                  frame_d = {1'b0, frame_q[9:1]};
                  count_d = count_q + 4'd1;
               end
            end else if (timer_q >= TW'(BIT_TIMEOUT)) begin
               state_d = ERROR;
            end
         end
         WAIT_RELEASE: begin
            if (clk_s2_q && dat_s2_q)
               state_d = DONE;
            else if (timer_q >= TW'(RELEASE_TIMEOUT))
               state_d = ERROR;
         end
         DONE:    state_d = IDLE;
         ERROR:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      timer_d = timer_q;
      if (state_d != state_q || restart)
         timer_d = '0;
      else if (timer_q != TW'(MAX_T))
         timer_d = timer_q + TW'(1);
   end

   // Outputs follow the next state so they are registered in step
   always_comb begin
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
      busy_d   = (state_d != IDLE);
      sent_d   = (state_d == DONE);
      err_d    = (state_d == ERROR);
      unique case (state_d)
         INHIBIT:    clk_oe_d = 1'b1;
         REQ: begin
            clk_oe_d = 1'b1;
            dat_oe_d = 1'b1;
         end
         WAIT_START: dat_oe_d = 1'b1;
         TX:         dat_oe_d = ~bit_d;
         default: begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
         end
      endcase
   end

   assign ps2_clk_oe                    = clk_oe_q;
   assign ps2_dat_oe                    = dat_oe_q;
   assign busy                          = busy_q;
   assign command_was_sent              = sent_q;
   assign error_communication_timed_out = err_q;

endmodule

// File: tb/tb_ps2_command_out.sv
// Directed bench for ps2_command_out with a simple
// open-drain PS/2 device model.
module tb_ps2_command_out;

   localparam int INH = 8;
   localparam int ST  = 40;
   localparam int BT  = 20;
   localparam int RT  = 20;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] the_command = 8'h00;
   logic       send_command = 1'b0;
   logic       dev_clk = 1'b1;
   logic       dev_dat = 1'b1;
   logic       ps2_clk_in, ps2_dat_in;
   logic       ps2_clk_oe, ps2_dat_oe;
   logic       busy, command_was_sent;
   logic       error_communication_timed_out;

   // Wired-AND of host and device drivers
   assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
   assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

   ps2_command_out #(
      .INHIBIT_CYCLES (INH),
      .START_TIMEOUT  (ST),
      .BIT_TIMEOUT    (BT),
      .RELEASE_TIMEOUT(RT)
   ) dut (
      .CLOCK_50                     (clk),
      .reset                        (reset),
      .the_command                  (the_command),
      .send_command                 (send_command),
      .ps2_clk_in                   (ps2_clk_in),
      .ps2_dat_in                   (ps2_dat_in),
      .ps2_clk_oe                   (ps2_clk_oe),
      .ps2_dat_oe                   (ps2_dat_oe),
      .busy                         (busy),
      .command_was_sent             (command_was_sent),
      .error_communication_timed_out(error_communication_timed_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   done_cnt = 0;
   int   err_cnt = 0;
   int   err_cyc = 0;
   logic pulse_prev = 1'b0;
   logic busy_after = 1'b1;
   logic oe_after = 1'b1;

   always @(negedge clk) begin
      pulse_prev <= command_was_sent | error_communication_timed_out;
      if (pulse_prev) begin
         busy_after <= busy;
         oe_after   <= ps2_clk_oe | ps2_dat_oe;
      end
      if (command_was_sent === 1'b1) done_cnt <= done_cnt + 1;
      if (error_communication_timed_out === 1'b1) begin
         err_cnt <= err_cnt + 1;
         err_cyc <= cyc;
      end
   end

   int tests = 0;
   int fails = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b);
      the_command  = b;
      send_command = 1'b1;
      tick(1);
      send_command = 1'b0;
      the_command  = 8'h00;
   endtask

   task automatic prefix(input string tag, output int t0);
      int n;
      n = 0;
      chk({tag, " busy"}, {31'd0, busy}, 32'd1);
      while (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b0 && n < 100) begin
         n++;
         tick(1);
      end
      chk({tag, " inhibit len"}, n, INH);
      chk({tag, " req"}, {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd3);
      tick(1);
      chk({tag, " wait_start"}, {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd1);
      t0 = cyc;
   endtask

   task automatic frame(input int nedges, input logic ack,
                        input logic glitch, output logic [9:0] s,
                        output int last_fall);
      s = '0;
      last_fall = 0;
      if (glitch) begin
         tick(1);
         the_command  = 8'h00;
         send_command = 1'b1;
         tick(1);
         send_command = 1'b0;
         tick(3);
      end else begin
         tick(5);
      end
      for (int i = 0; i < nedges; i++) begin
         if (i == 10) dev_dat = ~ack;
         dev_clk   = 1'b0;
         last_fall = cyc;
         tick(9);
         if (i < 10) s[i] = ps2_dat_oe;
         tick(1);
         dev_clk = 1'b1;
         dev_dat = 1'b1;
         tick(10);
      end
   endtask

   logic [9:0] s;
   int t0, lf, d0, e0;

   initial begin
      tick(3);
      chk("rst outs", {27'd0, ps2_clk_oe, ps2_dat_oe, busy,
          command_was_sent, error_communication_timed_out}, 32'd0);
      reset = 1'b0;
      tick(2);
      chk("idle busy", {31'd0, busy}, 32'd0);

      // 0xED: dat_oe per bit = ~{stop,par,data} = 10'h012
      d0 = done_cnt; e0 = err_cnt;
      send(8'hED);
      prefix("ed", t0);
      frame(11, 1'b1, 1'b0, s, lf);
      tick(10);
      chk("ed frame", {22'd0, s}, 32'h012);
      chk("ed done", done_cnt - d0, 32'd1);
      chk("ed no err", err_cnt - e0, 32'd0);
      chk("ed busy after", {31'd0, busy_after}, 32'd0);

      // 0xFF: eight ones, odd parity bit 1, dat_oe all 0
      d0 = done_cnt; e0 = err_cnt;
      send(8'hFF);
      prefix("ff", t0);
      frame(11, 1'b1, 1'b0, s, lf);
      tick(10);
      chk("ff frame", {22'd0, s}, 32'h000);
      chk("ff done", done_cnt - d0, 32'd1);
      chk("ff no err", err_cnt - e0, 32'd0);

      // Device never clocks
      d0 = done_cnt; e0 = err_cnt;
      send(8'hF4);
      prefix("nostart", t0);
      tick(50);
      chk("nostart err", err_cnt - e0, 32'd1);
      chk("nostart delay", err_cyc - t0, ST + 1);
      chk("nostart busy", {31'd0, busy_after}, 32'd0);
      chk("nostart oe", {31'd0, oe_after}, 32'd0);
      chk("nostart no done", done_cnt - d0, 32'd0);

      // Device stops after 4th edge: 2 sync + 1 register + BT+1
      d0 = done_cnt; e0 = err_cnt;
      send(8'hED);
      prefix("stall", t0);
      frame(4, 1'b1, 1'b0, s, lf);
      tick(20);
      chk("stall err", err_cnt - e0, 32'd1);
      chk("stall delay", err_cyc - lf, BT + 4);
      chk("stall oe", {31'd0, oe_after}, 32'd0);
      chk("stall busy", {31'd0, busy_after}, 32'd0);

      // Missing ACK
      d0 = done_cnt; e0 = err_cnt;
      send(8'hED);
      prefix("noack", t0);
      frame(11, 1'b0, 1'b0, s, lf);
      tick(10);
      chk("noack err", err_cnt - e0, 32'd1);
      chk("noack no done", done_cnt - d0, 32'd0);

      // Reset mid-TX after edge 5
      d0 = done_cnt; e0 = err_cnt;
      send(8'hF4);
      prefix("rst", t0);
      frame(5, 1'b1, 1'b0, s, lf);
      reset = 1'b1;
      tick(1);
      chk("midrst outs", {27'd0, ps2_clk_oe, ps2_dat_oe, busy,
          command_was_sent, error_communication_timed_out}, 32'd0);
      reset = 1'b0;
      tick(3);
      chk("midrst no pulse", (done_cnt - d0) + (err_cnt - e0), 32'd0);

      // 0xF4 with a stray request while busy: ~{1,0,F4} = 10'h10B
      d0 = done_cnt; e0 = err_cnt;
      send(8'hF4);
      prefix("f4", t0);
      frame(11, 1'b1, 1'b1, s, lf);
      tick(10);
      chk("f4 frame", {22'd0, s}, 32'h10B);
      chk("f4 done", done_cnt - d0, 32'd1);
      chk("f4 no err", err_cnt - e0, 32'd0);
      chk("f4 idle", {31'd0, busy}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
